eth_frame_tx: RTL and testbench

- Downstream neighbour of the payload store. Consumes its 2-bit payload stream, byte length and 16-bit payload checksum, and emits one complete Ethernet frame as an RMII-style dibit stream.
- Frame content, in transmit order: preamble/SFD, MAC header, 4-byte app header, payload, zero pad, CRC32 FCS, then inter-frame gap.
- Sits between the payload store and the RMII TX pins. One frame is sent per start pulse.

---
 rtl/eth_frame_tx.sv | 151 +++++++++++++++
 tb/tb_eth_frame_tx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_tx.sv
// eth_frame_tx: emits one Ethernet frame per start pulse as an RMII dibit stream.
// Header, pad and FCS are generated locally; payload dibits are pulled from the upstream store.
module eth_frame_tx #(
    parameter logic [47:0] DST_MAC   = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC   = 48'h00_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          READ_LEAD = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    input  logic [15:0] data_length,
    input  logic [15:0] data_cksum,
    input  logic        axi_last,
    output logic        read_request,
    output logic        axiov,
    output logic [1:0]  axiod,
    output logic        busy,
    output logic        err
);
    localparam logic [2:0] S_IDLE = 3'd0, S_PRE = 3'd1, S_HDR = 3'd2, S_PAY = 3'd3,
                           S_PAD = 3'd4, S_FCS = 3'd5, S_IFG = 3'd6, S_UND = 3'd7;
    localparam logic [12:0] RR_AT = 13'(71 - READ_LEAD);

    logic [2:0]   r_state;
    logic [5:0]   r_cnt;
    logic [12:0]  r_fcnt;
    logic [10:0]  r_bytes;
    logic [31:0]  r_crc, r_meta;
    logic         r_rr, r_axiov, r_busy, r_err;
    logic [1:0]   r_axiod;
    logic [2:0]   w_st;
    logic [143:0] w_hdr;
    logic [7:0]   w_hidx;
    logic [31:0]  w_fcs, w_crc;
    logic [1:0]   w_dib;
    logic         w_pad, w_pad_nx, w_unused;

    function automatic logic pad_need(input logic [12:0] f);
        return (f[1:0] != 2'd0) || (f < 13'd240);
    endfunction

    function automatic logic [31:0] crc2(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] a;
        a = (c >> 1) ^ ((c[0] ^ d[0]) ? 32'hEDB88320 : 32'd0);
        return (a >> 1) ^ ((a[0] ^ d[1]) ? 32'hEDB88320 : 32'd0);
    endfunction

    assign w_unused = axi_last;
    assign w_hdr    = {DST_MAC, SRC_MAC, ETHERTYPE, r_meta};
    assign w_hidx   = 8'd136 - {r_fcnt[6:2], 3'b000} + {5'd0, r_fcnt[1:0], 1'b0};
    assign w_fcs    = ~r_crc;
    assign w_pad    = pad_need(r_fcnt);
    assign w_pad_nx = pad_need(r_fcnt + 13'd1);
    // PAYLOAD resolves this cycle into forwarding, pad/FCS (no gap) or underrun
    assign w_st = (r_state != S_PAY) ? r_state :
                  axiiv ? ((r_bytes == 11'd1500) ? S_UND : S_PAY) :
                  (r_fcnt == 13'd72) ? S_UND : (w_pad ? S_PAD : S_FCS);
    assign w_dib = (w_st == S_PRE) ? ((r_cnt == 6'd31) ? 2'b11 : 2'b01) :
                   (w_st == S_HDR) ? w_hdr[w_hidx +: 2] :
                   (w_st == S_PAY) ? axiid :
                   (w_st == S_FCS) ? w_fcs[{r_cnt[3:0], 1'b0} +: 2] : 2'b00;
    assign w_crc = crc2(r_crc, w_dib);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_fcnt  <= 13'd0;
            r_bytes <= 11'd0;
            r_crc   <= 32'd0;
            r_meta  <= 32'd0;
            r_rr    <= 1'b0;
            r_axiov <= 1'b0;
            r_axiod <= 2'b00;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_axiov <= 1'b0;
            r_axiod <= 2'b00;
            r_err   <= 1'b0;
            r_rr    <= 1'b0;
            case (w_st)
                S_IDLE: if (start) begin
                    r_state <= S_PRE;
                    r_cnt   <= 6'd1;
                    r_fcnt  <= 13'd0;
                    r_bytes <= 11'd0;
                    r_crc   <= 32'hFFFFFFFF;
                    r_meta  <= {data_length, data_cksum};
                    r_axiov <= 1'b1;
                    r_axiod <= 2'b01;
                    r_busy  <= 1'b1;
                end
                S_PRE: begin
                    r_axiov <= 1'b1;
                    r_axiod <= w_dib;
                    r_cnt   <= (r_cnt == 6'd31) ? 6'd0 : r_cnt + 6'd1;
                    r_state <= (r_cnt == 6'd31) ? S_HDR : S_PRE;
                end
                S_HDR: begin
                    r_axiov <= 1'b1;
                    r_axiod <= w_dib;
                    r_crc   <= w_crc;
                    r_fcnt  <= r_fcnt + 13'd1;
                    r_rr    <= r_fcnt >= RR_AT;
                    r_state <= (r_fcnt == 13'd71) ? S_PAY : S_HDR;
                end
                S_PAY: begin
                    r_axiov <= 1'b1;
                    r_axiod <= w_dib;
                    r_crc   <= w_crc;
                    r_fcnt  <= r_fcnt + 13'd1;
                    r_rr    <= 1'b1;
                    r_bytes <= (r_fcnt[1:0] == 2'd3) ? r_bytes + 11'd1 : r_bytes;
                end
                S_PAD: begin
                    r_axiov <= 1'b1;
                    r_crc   <= w_crc;
                    r_fcnt  <= r_fcnt + 13'd1;
                    r_state <= w_pad_nx ? S_PAD : S_FCS;
                end
                S_FCS: begin
                    r_axiov <= 1'b1;
                    r_axiod <= w_dib;
                    r_cnt   <= (r_cnt == 6'd15) ? 6'd0 : r_cnt + 6'd1;
                    r_state <= (r_cnt == 6'd15) ? S_IFG : S_FCS;
                end
                S_IFG: begin
                    r_cnt   <= (r_cnt == 6'd48) ? 6'd0 : r_cnt + 6'd1;
                    r_state <= (r_cnt == 6'd48) ? S_IDLE : S_IFG;
                    r_busy  <= r_cnt != 6'd48;
                end
                S_UND: begin
                    r_err   <= 1'b1;
                    r_cnt   <= 6'd1;
                    r_state <= S_IFG;
                    r_bytes <= axiiv ? 11'd1501 : r_bytes;
                end
            endcase
        end
    end

    assign read_request = r_rr;
    assign axiov        = r_axiov;
    assign axiod        = r_axiod;
    assign busy         = r_busy;
    assign err          = r_err;
endmodule

// File: tb/tb_eth_frame_tx.sv
// tb_eth_frame_tx: random payload frames compared against a byte-level Ethernet frame model
// (header bytes, zero pad to 60 bytes, software CRC32 FCS) fed by a fixed-latency store model.
module tb_eth_frame_tx;
    localparam logic [47:0] DST  = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] SRC  = 48'h00_00_00_00_00_01;
    localparam logic [15:0] ETH  = 16'h88B5;
    localparam int          LEAD = 3;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, axiiv = 1'b0, axi_last = 1'b0;
    logic [1:0]  axiid = 2'b00;
    logic [15:0] data_length = 16'd0, data_cksum = 16'd0;
    logic        read_request, axiov, busy, err;
    logic [1:0]  axiod;
    int          n_chk = 0, n_fail = 0;
    logic [1:0]  pay[$];
    logic [1:0]  exp_q[$];
    logic [1:0]  got[$];
    int          sidx = 0;
    logic [3:0]  rrp = 4'd0;

    eth_frame_tx #(.DST_MAC(DST), .SRC_MAC(SRC), .ETHERTYPE(ETH), .READ_LEAD(LEAD)) dut (
        .clk(clk), .rst(rst), .start(start), .axiiv(axiiv), .axiid(axiid),
        .data_length(data_length), .data_cksum(data_cksum), .axi_last(axi_last),
        .read_request(read_request), .axiov(axiov), .axiod(axiod), .busy(busy), .err(err)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    // store: data appears on axiiv LEAD cycles after read_request is seen high
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (axiiv) sidx++;
            rrp = {rrp[2:0], read_request};
            axiiv = rrp[LEAD] && (sidx < pay.size());
            axiid = axiiv ? pay[sidx] : 2'b00;
            axi_last = axiiv && (sidx == pay.size() - 1);
        end
    end

    task automatic build_exp(input int n, input logic [15:0] len, input logic [15:0] ck);
        logic [7:0]   b[$];
        logic [143:0] h;
        logic [31:0]  c;
        logic [7:0]   v;
        exp_q.delete();
        repeat (31) exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
        h = {DST, SRC, ETH, len, ck};
        for (int k = 0; k < 18; k++) b.push_back(h[143 - 8*k -: 8]);
        if (n == 0 || n > 6000) begin
            foreach (b[k]) for (int j = 0; j < 4; j++) exp_q.push_back(b[k][2*j +: 2]);
            for (int i = 0; i < n && i < 6000; i++) exp_q.push_back(pay[i]);
        end else begin
            for (int i = 0; i < n; i += 4) begin
                v = 8'd0;
                for (int j = 0; j < 4 && i + j < n; j++) v = v | (8'(pay[i+j]) << (2*j));
                b.push_back(v);
            end
            while (b.size() < 60) b.push_back(8'd0);
            c = 32'hFFFFFFFF;
            foreach (b[k]) begin
                c = c ^ {24'd0, b[k]};
                repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
            c = ~c;
            for (int k = 0; k < 4; k++) b.push_back(c[8*k +: 8]);
            foreach (b[k]) for (int j = 0; j < 4; j++) exp_q.push_back(b[k][2*j +: 2]);
        end
    endtask

    task automatic run_frame(input int n, input logic [15:0] len, input logic [15:0] ck,
                             input int restart_at, input bit reuse);
        int cyc, first_v, low, gaps, nerr, err_cyc, nrr, first_rr, nbad, nv;
        bit ended, under;
        if (!reuse) begin
            pay.delete();
            repeat (n) pay.push_back(2'($urandom));
        end
        sidx = 0;
        under = (n == 0 || n > 6000);
        build_exp(n, len, ck);
        got.delete();
        first_v = 0; low = 0; gaps = 0; nerr = 0; err_cyc = 0; nrr = 0; first_rr = 0; ended = 0;
        @(negedge clk);
        start = 1'b1; data_length = len; data_cksum = ck;
        @(negedge clk);
        start = 1'b0; data_length = 16'($urandom); data_cksum = 16'($urandom);
        cyc = 1;
        while (busy && cyc < 9000) begin
            if (axiov) begin
                if (ended) gaps++;
                if (first_v == 0) first_v = cyc;
                got.push_back(axiod);
            end else if (first_v != 0) begin
                ended = 1;
                low++;
            end
            if (err) begin nerr++; err_cyc = cyc; end
            if (read_request) begin nrr++; if (first_rr == 0) first_rr = cyc; end
            start = (cyc == restart_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("busy_end", busy, 0);
        check("first_valid", first_v, 1);
        check("tx_dibits", got.size(), exp_q.size());
        nbad = 0;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) nbad++;
        check("tx_content", nbad, 0);
        check("tx_gaps", gaps, 0);
        check("ifg_cycles", low, 48);
        check("err_pulses", nerr, under);
        if (under) check("err_cycle", err_cyc, exp_q.size() + 1);
        check("rr_first", first_rr, 104 - LEAD);
        check("rr_cycles", nrr, (n > 6000 ? 6000 : n) + 4);
        if (restart_at > 0) begin
            nv = 0;
            repeat (30) begin
                @(negedge clk);
                if (axiov || busy) nv++;
            end
            check("no_requeue", nv, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_axiov", axiov, 0);
        check("rst_axiod", axiod, 0);
        check("rst_rr", read_request, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_busy", busy, 0);

        run_frame(32, 16'd8, 16'h1234, 0, 0);
        run_frame(400, 16'd100, 16'hBEEF, 0, 0);
        run_frame(6, 16'd2, 16'h0F0F, 0, 0);
        repeat (4) begin
            int n;
            n = $urandom_range(1, 400);
            run_frame(n, 16'(n / 4), 16'($urandom), 0, 0);
        end
        run_frame(0, 16'd0, 16'hAAAA, 0, 0);
        run_frame(24, 16'd6, 16'h5A5A, 53, 0);
        run_frame(24, 16'd6, 16'h5A5A, 0, 1);
        run_frame(6000, 16'd1500, 16'h1111, 0, 0);
        run_frame(6004, 16'd1501, 16'h2222, 0, 0);

        pay.delete();
        repeat (40) pay.push_back(2'($urandom));
        sidx = 0;
        @(negedge clk);
        start = 1'b1; data_length = 16'd10; data_cksum = 16'h7777;
        @(negedge clk);
        start = 1'b0;
        repeat (110) @(negedge clk);
        check("pre_rst_valid", axiov, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_axiov", axiov, 0);
        check("mid_rst_axiod", axiod, 0);
        check("mid_rst_rr", read_request, 0);
        check("mid_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_idle", busy, 0);
        run_frame(52, 16'd13, 16'hC0DE, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
